// File: rtl/fetch_decode_buffer_if.sv
// Fetch/decode handshake bundle: fetch side pushes entries, decode side pops the head.
interface fetch_decode_buffer_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_pcplus4;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pcplus4;

   // Environment side: drives fetch entries and decode acceptance.
   modport master (
      output in_valid, in_instr, in_pc, in_pcplus4, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_pcplus4
   );

   // Queue side.
   modport slave (
      input  in_valid, in_instr, in_pc, in_pcplus4, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_pcplus4
   );
endinterface

// File: rtl/fetch_decode_buffer.sv
// DEPTH-entry instruction queue between fetch and decode.
// Each entry holds instr, PC and PC+4; flush empties the queue on a redirect.
// Status outputs come only from registered count, so in_ready never depends on out_ready.
module fetch_decode_buffer #(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 4,
   parameter int              AFULL_TH     = DEPTH - 1,
   parameter logic [XLEN-1:0] BUBBLE_INSTR = '0,
   localparam int             CW           = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   fetch_decode_buffer_if.slave  bus,
   output logic [CW-1:0]         count,
   output logic                  almost_full
);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][XLEN-1:0] mem_instr;
   logic [DEPTH-1:0][XLEN-1:0] mem_pc;
   logic [DEPTH-1:0][XLEN-1:0] mem_pcplus4;
   logic [PW-1:0]              rd_ptr;
   logic [PW-1:0]              wr_ptr;
   logic                       push;
   logic                       pop;

   // Status decode from count only; full queue refuses input even when popping.
   always_comb begin
      bus.in_ready  = (count < CW'(DEPTH));
      bus.out_valid = (count != '0);
      almost_full   = (count >= CW'(AFULL_TH));
      push          = bus.in_valid  & bus.in_ready  & ~flush;
      pop           = bus.out_valid & bus.out_ready & ~flush;
   end

   // Head presentation; bubble values hide stale or never-written slots.
   always_comb begin
      bus.out_instr   = BUBBLE_INSTR;
      bus.out_pc      = '0;
      bus.out_pcplus4 = '0;
      if (bus.out_valid) begin
         bus.out_instr   = mem_instr[rd_ptr];
         bus.out_pc      = mem_pc[rd_ptr];
         bus.out_pcplus4 = mem_pcplus4[rd_ptr];
      end
   end

   // Entry storage; no reset needed since reads are gated by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr]   <= bus.in_instr;
         mem_pc[wr_ptr]      <= bus.in_pc;
         mem_pcplus4[wr_ptr] <= bus.in_pcplus4;
      end
   end

   // Pointer and occupancy bookkeeping: reset > flush > push/pop.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end
endmodule
